seg7_scan_ctrl: RTL and testbench

Parametrised multi-digit seven-segment scan controller that displays a debug value (e.g. data-memory words) on the board's common-anode display. It generalises the fixed 5-digit display scanner to `DIGITS` digits, with these additions:
- a programmable per-digit slot time;
- anti-ghosting blank time;
- per-digit enable and decimal-point masks;
- leading-zero suppression;
- a valid/ready load port whose data is applied only at frame boundaries, so the display never tears.

It sits between the core's debug outputs and the FPGA pins.

---
 rtl/seg7_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multi-digit common-anode seven-segment scanner with blanking, digit/dp masks,
// leading-zero suppression and a valid/ready load port that commits only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000,
  parameter int BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*DIGITS-1:0]   wr_value,
  input  logic [DIGITS-1:0]     wr_en,
  input  logic [DIGITS-1:0]     wr_dp,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_TOP   = IW'(DIGITS - 1);

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_value_q, pend_value_d, disp_value_q, disp_value_d;
  logic [DIGITS-1:0]   pend_en_q, pend_en_d, disp_en_q, disp_en_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                full_q, full_d, wr_ready_q, wr_ready_d;
  logic                lit_q, lit_d, dp_q, dp_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   anode_q, anode_d;

  logic                slot_end, frame_end;
  logic                run, sup_next, en_next, dp_next;
  logic [3:0]          nib_next;

  assign slot_end   = (cnt_q == CNT_LAST);
  assign frame_end  = slot_end && (idx_q == '0);
  assign frame_tick = frame_end;
  assign wr_ready   = wr_ready_q;
  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

  always_comb begin
    // NOTE: every variable gets a default here first so no path leaves it unassigned (no latches).
    cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    pend_value_d = pend_value_q;
    pend_en_d    = pend_en_q;
    pend_dp_d    = pend_dp_q;
    full_d       = full_q;
    disp_value_d = disp_value_q;
    disp_en_d    = disp_en_q;
    disp_dp_d    = disp_dp_q;
    lit_d        = lit_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    anode_d      = '1;
    run          = 1'b1;
    sup_next     = 1'b0;
    en_next      = 1'b0;
    dp_next      = 1'b0;
    nib_next     = 4'h0;

    if (slot_end) idx_d = (idx_q == '0) ? IDX_TOP : idx_q - IW'(1);

    if (wr_valid && wr_ready_q) begin
      pend_value_d = wr_value;
      pend_en_d    = wr_en;
      pend_dp_d    = wr_dp;
      full_d       = 1'b1;
    end
    // Acceptance needs !full, so it never coincides with a transfer.
    if (frame_end && full_q) begin
      disp_value_d = pend_value_q;
      disp_en_d    = pend_en_q;
      disp_dp_d    = pend_dp_q;
      full_d       = 1'b0;
    end
    wr_ready_d = ~full_d;

    // Walk from the leftmost digit: run stays high while every digit so far is a bare zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run & (disp_value_d[4*i +: 4] == 4'h0) & ~disp_dp_d[i];
      if (idx_d == IW'(i)) begin
        nib_next = disp_value_d[4*i +: 4];
        en_next  = disp_en_d[i];
        dp_next  = disp_dp_d[i];
        sup_next = (i != 0) && run;
      end
    end

    // Digit content and visibility are frozen for the whole slot being entered.
    if (slot_end) begin
      lit_d = en_next & ~(lz_en & sup_next);
      seg_d = decode(nib_next);
      dp_d  = ~dp_next;
    end

    for (int i = 0; i < DIGITS; i++) begin
      if ((idx_d == IW'(i)) && lit_d && (cnt_d >= CNT_BLANK)) anode_d[i] = 1'b0;
    end
  end

  // NOTE: the pending and display storage is reset too, so the display is blank until the first load lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= IDX_TOP;
      pend_value_q <= '0;
      pend_en_q    <= '0;
      pend_dp_q    <= '0;
      full_q       <= 1'b0;
      wr_ready_q   <= 1'b1;
      disp_value_q <= '0;
      disp_en_q    <= '0;
      disp_dp_q    <= '0;
      lit_q        <= 1'b0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      anode_q      <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_value_q <= pend_value_d;
      pend_en_q    <= pend_en_d;
      pend_dp_q    <= pend_dp_d;
      full_q       <= full_d;
      wr_ready_q   <= wr_ready_d;
      disp_value_q <= disp_value_d;
      disp_en_q    <= disp_en_d;
      disp_dp_q    <= disp_dp_d;
      lit_q        <= lit_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      anode_q      <= anode_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: accepted loads are queued as display images,
// and a monitor checks every frame against a digit-level model of the display.
module tb_seg7_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_value = '0;
  logic [3:0]  wr_en = '0;
  logic [3:0]  wr_dp = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_value(wr_value), .wr_en(wr_en), .wr_dp(wr_dp),
    .lz_en(lz_en),
    .anode(anode), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  en;
    logic [3:0]  dp;
  } image_t;

  image_t pend_q[$];
  image_t cur;
  int checks = 0;
  int failures = 0;

  logic [6:0] seg_table [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // A digit shows unless masked off, or it sits in a run of bare zeros starting at the left.
  function automatic logic digit_lit(input image_t im, input logic lz, input int d);
    if (!im.en[d]) return 1'b0;
    if (!lz || d == 0) return 1'b1;
    for (int j = d; j < DIGITS; j++)
      if (im.value[4*j +: 4] != 4'h0 || im.dp[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: frame position k counts from the cycle after a frame_tick.
  initial begin
    int k, d, p, unsync_cnt;
    bit synced, slot_lit;
    logic lz_last;
    logic [3:0] exp_anode;
    k = 0; synced = 0; slot_lit = 0; unsync_cnt = 0; lz_last = 1'b0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        synced = 0;
        unsync_cnt = 0;
        pend_q.delete();
        cur = '0;
        check("rst_hold_anode", anode, 4'hF);
        check("rst_hold_ready", wr_ready, 1);
        check("rst_hold_tick", frame_tick, 0);
      end else begin
        check("wr_ready", wr_ready, pend_q.size() == 0);
        if (!synced) begin
          check("anode_presync", anode, 4'hF);
          unsync_cnt++;
          if (unsync_cnt == FRAME + 1) bound_fail("first_frame_tick");
          if (frame_tick) begin
            synced = 1;
            k = 0;
            if (pend_q.size() != 0) cur = pend_q.pop_front();
          end
        end else begin
          p = k % DIV;
          d = DIGITS - 1 - k / DIV;
          if (p == 0) slot_lit = digit_lit(cur, lz_last, d);
          exp_anode = 4'hF;
          if (p >= BLANK && slot_lit) exp_anode[d] = 1'b0;
          check("anode", anode, exp_anode);
          check("frame_tick", frame_tick, k == FRAME - 1);
          if (exp_anode[d] == 1'b0) begin
            check("seg", seg, seg_table[cur.value[4*d +: 4]]);
            check("dp", dp, !cur.dp[d]);
          end
          if (k == FRAME - 1) begin
            if (pend_q.size() != 0) cur = pend_q.pop_front();
            k = 0;
          end else begin
            k++;
          end
        end
      end
      lz_last = lz_en;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_anode"}, anode, 4'hF);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"}, dp, 1);
    check({tag, "_ready"}, wr_ready, 1);
    check({tag, "_tick"}, frame_tick, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; the image is queued right after the accepting edge.
  task automatic load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpm,
                      input logic lz);
    int waited;
    image_t im;
    wr_value = v; wr_en = en; wr_dp = dpm; lz_en = lz; wr_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!wr_ready && waited < 3 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    if (!wr_ready) begin
      bound_fail("load_accept");
      wr_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    im.value = v; im.en = en; im.dp = dpm;
    pend_q.push_back(im);
    wr_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_tick && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (!frame_tick) bound_fail("wait_frame_tick");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] v;
    logic [3:0]  en, dpm;
    @(posedge clk);
    #1;
    pulse_reset("por");
    wait_cycles(3 * FRAME + 4);

    wait_cycles(13);
    pulse_reset("mid");

    load(16'h13AF, 4'hF, 4'h0, 1'b0);
    wait_cycles(2 * FRAME + DIV);

    load(16'h1111, 4'hF, 4'h0, 1'b0);
    load(16'h2222, 4'hF, 4'h0, 1'b0);
    wait_cycles(3 * FRAME);

    load(16'h0030, 4'hF, 4'h0, 1'b1);
    wait_cycles(2 * FRAME);
    load(16'h0000, 4'hF, 4'h0, 1'b1);
    wait_cycles(2 * FRAME);

    load(16'h0005, 4'b1010, 4'b0100, 1'b1);
    wait_cycles(2 * FRAME);

    repeat (24) begin
      v = 16'($urandom);
      v = v >> (4 * $urandom_range(0, 4));
      en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      dpm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load(v, en, dpm, 1'($urandom));
      wait_cycles($urandom_range(0, 40));
      lz_en = 1'($urandom);
      wait_cycles($urandom_range(0, 20));
    end
    wait_cycles(2 * FRAME);

    wait_tick();
    load(16'h9876, 4'hF, 4'h0, 1'b0);
    wait_cycles(4);
    pulse_reset("pend");
    wait_cycles(3 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
